// File: rtl/gen_spi_if.sv
// rtl/gen_spi_if.sv - register-mapped SPI master with per-device chip selects
// Four-register bus slave driving a tick-paced IDLE/SETUP/LEAD/TRAIL/GAP serial engine.
module gen_spi_if #(
  parameter int NUM_DEVICES = 1,
  parameter int MAX_BITS    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   wr_i,
  input  logic [3:0]             wstrb_i,
  input  logic [1:0]             address_i,
  input  logic [31:0]            dat_i,
  output logic [31:0]            dat_o,
  output logic                   ack_o,
  output logic                   DEV_SCLK,
  output logic                   DEV_MOSI,
  output logic [NUM_DEVICES-1:0] DEV_CS_B,
  input  logic [NUM_DEVICES-1:0] DEV_MISO,
  output logic                   irq_o
);
  localparam logic [7:0]  SEL_MASK  = 8'hFF >> (8 - NUM_DEVICES);
  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - MAX_BITS);
  localparam logic [4:0]  NB_MAX    = 5'(MAX_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, GAP} state_t;
  state_t state;

  logic [7:0]  prescale, cnt, dev_sel, sel_new;
  logic        cpol, cpha, lsb_first, irq_en;
  logic [3:0]  cs_gap, gap_cnt;
  logic [4:0]  nbits_m1, nb_start, idx, samp_pos, pos_cur, pos_nxt, pos_first;
  logic [31:0] tx_data, rx_data, byte_mask;
  logic        done, busy, overrun, miso_q, samp_pend;
  logic        wr_go, rd_go, tick, start_ok, miso_sel;

  always_comb begin
    wr_go     = en_i && ack_o && wr_i;
    rd_go     = en_i && ack_o && !wr_i;
    tick      = (cnt == prescale);
    byte_mask = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}}, {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};
    sel_new   = wstrb_i[0] ? (dat_i[7:0] & SEL_MASK) : dev_sel;
    nb_start  = !wstrb_i[2] ? nbits_m1 : ((dat_i[20:16] > NB_MAX) ? NB_MAX : dat_i[20:16]);
    start_ok  = wr_go && (address_i == 2'd1) && wstrb_i[3] && dat_i[30] && !busy
                && (sel_new != 8'd0);
    pos_cur   = lsb_first ? idx : nbits_m1 - idx;
    pos_nxt   = lsb_first ? idx + 5'd1 : nbits_m1 - idx - 5'd1;
    pos_first = lsb_first ? 5'd0 : nb_start;
    // Descending scan so the lowest-numbered selected device wins.
    miso_sel  = 1'b0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--)
      if (dev_sel[i]) miso_sel = DEV_MISO[i];
  end

  assign irq_o = done & irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;  prescale <= '0;  cnt <= '0;  dev_sel <= '0;
      cpol <= 1'b0;  cpha <= 1'b0;  lsb_first <= 1'b0;  irq_en <= 1'b0;
      cs_gap <= '0;  gap_cnt <= '0;  nbits_m1 <= '0;  idx <= '0;  samp_pos <= '0;
      tx_data <= '0;  rx_data <= '0;  done <= 1'b0;  busy <= 1'b0;  overrun <= 1'b0;
      miso_q <= 1'b0;  samp_pend <= 1'b0;  ack_o <= 1'b0;  dat_o <= '0;
      DEV_SCLK <= 1'b0;  DEV_MOSI <= 1'b0;  DEV_CS_B <= '1;
    end else begin
      ack_o     <= en_i;
      miso_q    <= miso_sel;
      samp_pend <= 1'b0;
      // Capture one clock after the sampling edge so miso_q reflects the line at that edge.
      if (samp_pend) rx_data[samp_pos] <= miso_q;

      if (rd_go) begin
        case (address_i)
          2'd0: dat_o <= {16'd0, cs_gap, irq_en, lsb_first, cpha, cpol, prescale};
          2'd1: dat_o <= {busy, 10'd0, nbits_m1, 8'd0, dev_sel};
          2'd2: dat_o <= rx_data;
          default: dat_o <= {29'd0, overrun, busy, done};
        endcase
      end

      if (wr_go) begin
        if (busy && address_i != 2'd3) overrun <= 1'b1;
        else begin
          case (address_i)
            2'd0: begin
              if (wstrb_i[0]) prescale <= dat_i[7:0];
              if (wstrb_i[1]) {cs_gap, irq_en, lsb_first, cpha, cpol} <= dat_i[15:8];
            end
            2'd1: begin
              dev_sel  <= sel_new;
              nbits_m1 <= nb_start;
            end
            2'd2: tx_data <= ((tx_data & ~byte_mask) | (dat_i & byte_mask)) & DATA_MASK;
            default: if (wstrb_i[0]) begin
              if (dat_i[0]) done <= 1'b0;
              if (dat_i[2]) overrun <= 1'b0;
            end
          endcase
        end
      end

      if (state != IDLE) cnt <= tick ? 8'd0 : cnt + 8'd1;

      case (state)
        IDLE: begin
          DEV_SCLK <= cpol;
          if (start_ok) begin
            state    <= SETUP;
            busy     <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            rx_data  <= '0;
            DEV_CS_B <= ~sel_new[NUM_DEVICES-1:0];
            if (!cpha) DEV_MOSI <= tx_data[pos_first];
          end
        end
        SETUP: if (tick) begin
          state    <= LEAD;
          DEV_SCLK <= !cpol;
          if (cpha) DEV_MOSI <= tx_data[pos_cur];
          else begin samp_pend <= 1'b1; samp_pos <= pos_cur; end
        end
        LEAD: if (tick) begin
          state    <= TRAIL;
          DEV_SCLK <= cpol;
          if (cpha) begin samp_pend <= 1'b1; samp_pos <= pos_cur; end
          else if (idx != nbits_m1) DEV_MOSI <= tx_data[pos_nxt];
        end
        TRAIL: if (tick) begin
          if (idx == nbits_m1) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            idx      <= idx + 5'd1;
            state    <= LEAD;
            DEV_SCLK <= !cpol;
            if (cpha) DEV_MOSI <= tx_data[pos_nxt];
            else begin samp_pend <= 1'b1; samp_pos <= pos_nxt; end
          end
        end
        GAP: if (tick) begin
          if (gap_cnt == cs_gap) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            DEV_CS_B <= '1;
          end else gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gen_spi_if.sv
// tb/tb_gen_spi_if.sv - directed self-checking bench for gen_spi_if
// Four devices; MISO either loops back MOSI on device 0 or follows a fixed vector.
module tb_gen_spi_if;
  logic        clk = 1'b0;
  logic        rst_n, en, wr;
  logic [3:0]  wstrb;
  logic [1:0]  addr;
  logic [31:0] wdat, rdat;
  logic        ack, sclk, mosi, irq;
  logic [3:0]  cs_b, miso, miso_vec;
  logic        loop;
  int          checks = 0;
  int          errors = 0;

  assign miso = loop ? {miso_vec[3:1], mosi} : miso_vec;

  gen_spi_if #(.NUM_DEVICES(4), .MAX_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .wr_i(wr), .wstrb_i(wstrb),
    .address_i(addr), .dat_i(wdat), .dat_o(rdat), .ack_o(ack),
    .DEV_SCLK(sclk), .DEV_MOSI(mosi), .DEV_CS_B(cs_b), .DEV_MISO(miso), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = a; wdat = d;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    @(negedge clk);
    d = rdat;
    en = 1'b0;
  endtask

  // Called at the negedge right after the START edge; runs until CS returns high.
  task automatic capture(input logic pol, output int pulses, output logic [31:0] seq,
                         output int act, output int csl, output logic [3:0] cs_seen);
    logic prev;
    int   n;
    pulses = 0; seq = '0; act = 0; csl = 0; cs_seen = 4'hF; prev = pol; n = 0;
    while (n < 2000) begin
      if (cs_b != 4'hF) begin csl++; cs_seen = cs_b; end
      else if (n > 0) break;
      if (sclk != pol) begin
        act++;
        if (prev == pol) begin pulses++; seq = {seq[30:0], mosi}; end
      end
      prev = sclk;
      n++;
      @(negedge clk);
    end
    chk("capture_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cs_b != 4'hF && n < 1000) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    int          pulses, act, csl, edges, guard;
    logic [31:0] seq, d;
    logic [3:0]  cs_seen;
    logic        any_low;
    logic        prev;

    rst_n = 1'b0; en = 1'b0; wr = 1'b0; wstrb = 4'hF; addr = '0; wdat = '0;
    loop = 1'b0; miso_vec = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_cs_b", 32'(cs_b), 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat_o", rdat, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    bus_write(2'd1, 32'h001F_00FF);
    bus_read(2'd1, d);
    chk("ctrl_sel_mask", d, 32'h001F_000F);

    // DEV_SEL==0 START must not select anything.
    bus_write(2'd1, 32'h4007_0000);
    any_low = 1'b0;
    repeat (6) begin @(negedge clk); if (cs_b != 4'hF) any_low = 1'b1; end
    chk("nosel_cs", 32'(any_low), 32'd0);
    bus_read(2'd1, d);
    chk("nosel_ctrl", d, 32'h0007_0000);

    // V-1 loopback, mode 0, MSB first, 1-clock ticks.
    loop = 1'b1;
    bus_write(2'd0, 32'h0000_0000);
    bus_write(2'd2, 32'h0000_00A5);
    bus_write(2'd1, 32'h4007_0001);
    capture(1'b0, pulses, seq, act, csl, cs_seen);
    chk("v1_pulses", 32'(pulses), 32'd8);
    chk("v1_mosi", seq, 32'h0000_00A5);
    chk("v1_high", 32'(act), 32'd8);
    bus_read(2'd2, d);
    chk("v1_rx", d, 32'h0000_00A5);
    bus_read(2'd3, d);
    chk("v1_status", d, 32'h0000_0001);

    // V-2 mode 3, LSB first, MISO tied high.
    loop = 1'b0; miso_vec = 4'hF;
    bus_write(2'd0, 32'h0000_0701);
    @(negedge clk);
    chk("v2_sclk_idle", 32'(sclk), 32'd1);
    bus_write(2'd2, 32'h0000_1234);
    bus_write(2'd1, 32'h400F_0001);
    capture(1'b1, pulses, seq, act, csl, cs_seen);
    chk("v2_pulses", 32'(pulses), 32'd16);
    chk("v2_mosi", seq, 32'h0000_2C48);
    chk("v2_active", 32'(act), 32'd32);
    bus_read(2'd2, d);
    chk("v2_rx", d, 32'h0000_FFFF);

    // V-3 timing with prescale and CS gap; also the interrupt.
    bus_write(2'd3, 32'h0000_0001);
    bus_write(2'd0, 32'h0000_2803);
    bus_read(2'd0, d);
    chk("v3_config", d, 32'h0000_2803);
    bus_write(2'd1, 32'h4000_0001);
    capture(1'b0, pulses, seq, act, csl, cs_seen);
    chk("v3_cs_clks", 32'(csl), 32'd24);
    chk("v3_high", 32'(act), 32'd4);
    chk("v3_pulses", 32'(pulses), 32'd1);
    @(negedge clk);
    chk("v3_irq_set", 32'(irq), 32'd1);
    bus_write(2'd3, 32'h0000_0001);
    chk("v3_irq_clr", 32'(irq), 32'd0);
    bus_read(2'd3, d);
    chk("v3_status", d, 32'h0000_0000);

    // V-4 writes while busy are dropped and flagged.
    loop = 1'b1;
    bus_write(2'd0, 32'h0000_0003);
    bus_write(2'd2, 32'h0000_00C3);
    bus_write(2'd1, 32'h4007_0001);
    bus_read(2'd1, d);
    chk("v4_ctrl_busy", d, 32'h8007_0001);
    bus_write(2'd1, 32'h4007_0001);
    bus_write(2'd2, 32'h0000_00FF);
    wait_idle();
    @(negedge clk);
    bus_read(2'd2, d);
    chk("v4_rx", d, 32'h0000_00C3);
    bus_read(2'd3, d);
    chk("v4_status", d, 32'h0000_0005);
    bus_write(2'd3, 32'h0000_0004);
    bus_read(2'd3, d);
    chk("v4_ovr_clr", d, 32'h0000_0001);

    // V-5 two devices selected, lowest one supplies MISO.
    loop = 1'b0; miso_vec = 4'b1010;
    bus_write(2'd0, 32'h0000_0000);
    bus_write(2'd1, 32'h4007_0006);
    capture(1'b0, pulses, seq, act, csl, cs_seen);
    chk("v5_cs_b", 32'(cs_seen), 32'h9);
    bus_read(2'd2, d);
    chk("v5_rx", d, 32'h0000_00FF);

    // V-6 reset in the middle of a 32-bit transfer.
    miso_vec = 4'hF;
    bus_write(2'd0, 32'h0000_0001);
    bus_write(2'd2, 32'hDEAD_BEEF);
    bus_write(2'd1, 32'h401F_0001);
    edges = 0; guard = 0; prev = sclk;
    while (edges < 5 && guard < 500) begin
      @(negedge clk);
      if (sclk && !prev) edges++;
      prev = sclk;
      guard++;
    end
    chk("v6_reach_bit5", 32'(edges), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("v6_cs_b", 32'(cs_b), 32'hF);
    chk("v6_sclk", 32'(sclk), 32'd0);
    chk("v6_mosi", 32'(mosi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(2'd3, d);
    chk("v6_status", d, 32'h0000_0000);
    bus_read(2'd2, d);
    chk("v6_rx", d, 32'h0000_0000);
    chk("v6_sclk_cpol", 32'(sclk), 32'd0);

    // Cold-start transfer after reset.
    loop = 1'b1;
    bus_write(2'd2, 32'h0000_003C);
    bus_write(2'd1, 32'h4007_0001);
    capture(1'b0, pulses, seq, act, csl, cs_seen);
    chk("cold_mosi", seq, 32'h0000_003C);
    bus_read(2'd2, d);
    chk("cold_rx", d, 32'h0000_003C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
